// File: rtl/rbm_vote_controller_pkg.sv
// Shared definitions for the RBM vote controller: FSM encoding, packed-port
// slice macro and the class-index width helper.
`ifndef RBM_VOTE_CONTROLLER_PKG_SV
`define RBM_VOTE_CONTROLLER_PKG_SV

// Selects element idx of width w from a flat packed vector.
`define RBM_SLICE(idx, w) [(idx)*(w) +: (w)]

package rbm_vote_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SCAN,
        ST_DONE
    } state_t;

    function automatic int cid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/rbm_vote_controller_vote_argmax.sv
// Sequential argmax over packed vote counters: one class per cycle, ties
// resolve to the lowest index because only a strictly greater count wins.
module vote_argmax
    import rbm_vote_controller_pkg::*;
#(
    parameter int output_dim      = 10,
    parameter int count_bitlength = 12
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start_scan,
    input  logic [output_dim*count_bitlength-1:0]   votes,
    output logic [cid_width(output_dim)-1:0]        class_id,
    output logic                                    done
);
    localparam int CW = cid_width(output_dim);

    logic [CW-1:0]              r_idx;
    logic [CW-1:0]              r_best;
    logic [count_bitlength-1:0] r_max;
    logic                       r_active;
    logic [count_bitlength-1:0] w_cur;

    assign w_cur    = votes `RBM_SLICE(r_idx, count_bitlength);
    assign done     = r_active && (r_idx == CW'(output_dim - 1));
    assign class_id = r_best;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_best   <= '0;
            r_max    <= '0;
        end else if (start_scan) begin
            r_active <= 1'b1;
            r_idx    <= '0;
            r_best   <= '0;
            r_max    <= '0;
        end else if (r_active) begin
            if (w_cur > r_max) begin
                r_max  <= w_cur;
                r_best <= r_idx;
            end
            if (done) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbm_vote_controller.sv
// Stochastic RBM inference sequencer: re-arms the layers each pass, counts
// per-class votes, then resolves the winner. Optional: VOTE_EARLY_STOP_EN.
module rbm_vote_controller
    import rbm_vote_controller_pkg::*;
#(
    parameter int output_dim      = 10,
    parameter int count_bitlength = 12,
    parameter int iter_bitlength  = 10,
    parameter int iteration_num   = 100,
    parameter int early_margin    = 60
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    output logic                                    layer_reset,
    input  logic                                    layer_finish,
    input  logic [output_dim-1:0]                   sample,
    output logic [output_dim*count_bitlength-1:0]   votes,
    output logic [cid_width(output_dim)-1:0]        class_id,
    output logic                                    result_valid,
    input  logic                                    result_ready,
    output logic                                    busy,
    output logic [iter_bitlength-1:0]               iterations_done
);
`ifdef VOTE_EARLY_STOP_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [iter_bitlength-1:0]  r_iter;
    logic [iter_bitlength-1:0]  w_iter_inc;
    logic [count_bitlength-1:0] r_votes     [output_dim];
    logic [count_bitlength-1:0] w_votes_nxt [output_dim];
    logic                       w_clear;
    logic                       w_accum;
    logic                       w_scan_start;
    logic                       w_scan_done;
    logic                       w_scan_rst;
    logic                       w_margin_hit;

    function automatic logic [count_bitlength-1:0] sat_inc(
        input logic [count_bitlength-1:0] v,
        input logic                       inc
    );
        if (inc && (v != '1)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    assign w_iter_inc = r_iter + 1'b1;

    always_comb begin
        w_margin_hit = 1'b0;
        for (int i = 0; i < output_dim; i++) begin
            w_votes_nxt[i] = sat_inc(r_votes[i], sample[i]);
            if (int'(w_votes_nxt[i]) >= early_margin) begin
                w_margin_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_accum      = 1'b0;
        w_scan_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (layer_finish) begin
                    w_accum = 1'b1;
                    if ((w_iter_inc == iter_bitlength'(iteration_num)) ||
                        (EARLY_EN && w_margin_hit)) begin
                        w_scan_start = 1'b1;
                        w_state_nxt  = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                    end
                end
            end
            ST_SCAN: begin
                if (w_scan_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            for (int i = 0; i < output_dim; i++) begin
                r_votes[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_iter <= '0;
                for (int i = 0; i < output_dim; i++) begin
                    r_votes[i] <= '0;
                end
            end else if (w_accum) begin
                r_iter <= w_iter_inc;
                for (int i = 0; i < output_dim; i++) begin
                    r_votes[i] <= w_votes_nxt[i];
                end
            end
        end
    end

    for (genvar gi = 0; gi < output_dim; gi++) begin : g_pack
        assign votes `RBM_SLICE(gi, count_bitlength) = r_votes[gi];
    end

    // An accepted start also clears the previous winner held in the scanner.
    assign w_scan_rst = reset | w_clear;

    vote_argmax #(
        .output_dim      (output_dim),
        .count_bitlength (count_bitlength)
    ) u_argmax (
        .clock      (clock),
        .reset      (w_scan_rst),
        .start_scan (w_scan_start),
        .votes      (votes),
        .class_id   (class_id),
        .done       (w_scan_done)
    );

    assign layer_reset     = (r_state != ST_RUN);
    assign busy            = (r_state != ST_IDLE);
    assign result_valid    = (r_state == ST_DONE);
    assign iterations_done = r_iter;

endmodule

// File: tb/tb_rbm_vote_controller.sv
// Directed bench for rbm_vote_controller: table-driven classifications plus
// hand sequences for DONE stall, mid-run reset, held finish and saturation.
module tb_rbm_vote_controller;

    logic         clock;
    logic         reset;
    logic         start;
    logic         layer_reset;
    logic         layer_finish;
    logic [9:0]   sample;
    logic [119:0] votes;
    logic [3:0]   class_id;
    logic         result_valid;
    logic         result_ready;
    logic         busy;
    logic [9:0]   iterations_done;

    logic         start2;
    logic         layer_reset2;
    logic         layer_finish2;
    logic [9:0]   sample2;
    logic [19:0]  votes2;
    logic [3:0]   class_id2;
    logic         result_valid2;
    logic         result_ready2;
    logic         busy2;
    logic [9:0]   iterations_done2;

    int errors = 0;
    int checks = 0;

    rbm_vote_controller #(
        .output_dim(10), .count_bitlength(12), .iter_bitlength(10),
        .iteration_num(4), .early_margin(60)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .layer_reset(layer_reset),
        .layer_finish(layer_finish), .sample(sample), .votes(votes),
        .class_id(class_id), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy),
        .iterations_done(iterations_done)
    );

    rbm_vote_controller #(
        .output_dim(10), .count_bitlength(2), .iter_bitlength(10),
        .iteration_num(6), .early_margin(3)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start2), .layer_reset(layer_reset2),
        .layer_finish(layer_finish2), .sample(sample2), .votes(votes2),
        .class_id(class_id2), .result_valid(result_valid2),
        .result_ready(result_ready2), .busy(busy2),
        .iterations_done(iterations_done2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        int         dly;
        int         exp_cls;
        int         exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Votes after 4 passes alternating a, b: each pattern contributes twice.
    function automatic logic [119:0] exp_votes(input logic [9:0] a, input logic [9:0] b);
        logic [119:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[i*12 +: 12] = (12'(a[i]) + 12'(b[i])) << 1;
        end
        return r;
    endfunction

    // Layer model: finish on the dly-th RUN cycle, sample alternating a/b.
    // Returns with the DUT in DONE (not yet accepted); lat = cycles from start.
    task automatic run_cls(input logic [9:0] a, input logic [9:0] b, input int dly, output int lat);
        int rc;
        int pass;
        int cyc;
        rc = 0;
        pass = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("clear_layer_reset", 128'(layer_reset), 128'(1));
        chk("clear_class_cleared", 128'(class_id), 128'(0));
        while (!result_valid && cyc < 400) begin
            if (!layer_reset) begin
                rc++;
                if (rc == dly) begin
                    layer_finish = 1'b1;
                    sample = pass[0] ? b : a;
                    pass++;
                    rc = 0;
                end else begin
                    layer_finish = 1'b0;
                end
            end else begin
                rc = 0;
                layer_finish = 1'b0;
            end
            tick();
            cyc++;
        end
        layer_finish = 1'b0;
        lat = cyc;
        if (!result_valid) begin
            chk("result_valid_timeout", 128'(result_valid), 128'(1));
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("accept_busy_low", 128'(busy), 128'(0));
        chk("accept_valid_low", 128'(result_valid), 128'(0));
    endtask

    initial begin
        int lat;
        logic [119:0] ev;
        logic [19:0] ev2;

        vecs[0] = '{a: 10'b00_0000_0100, b: 10'b00_0000_0100, dly: 3, exp_cls: 2, exp_lat: 27};
        vecs[1] = '{a: 10'b00_0000_1000, b: 10'b00_1000_0000, dly: 1, exp_cls: 3, exp_lat: 19};
        vecs[2] = '{a: 10'b11_1111_1111, b: 10'b10_0000_0000, dly: 2, exp_cls: 9, exp_lat: 23};
        vecs[3] = '{a: 10'b00_0000_0000, b: 10'b00_0000_0000, dly: 1, exp_cls: 0, exp_lat: 19};
        vecs[4] = '{a: 10'b00_0010_0001, b: 10'b00_0010_0000, dly: 4, exp_cls: 5, exp_lat: 31};

        reset = 1'b1;
        start = 1'b0;
        layer_finish = 1'b0;
        sample = '0;
        result_ready = 1'b0;
        start2 = 1'b0;
        layer_finish2 = 1'b0;
        sample2 = '0;
        result_ready2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_layer_reset", 128'(layer_reset), 128'(1));
        chk("rst_votes", 128'(votes), 128'(0));
        chk("rst_class_id", 128'(class_id), 128'(0));
        chk("rst_valid", 128'(result_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_iter", 128'(iterations_done), 128'(0));

        for (int v = 0; v < 5; v++) begin
            ev = exp_votes(vecs[v].a, vecs[v].b);
            run_cls(vecs[v].a, vecs[v].b, vecs[v].dly, lat);
            chk($sformatf("v%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
            chk($sformatf("v%0d_class", v), 128'(class_id), 128'(vecs[v].exp_cls));
            chk($sformatf("v%0d_iter", v), 128'(iterations_done), 128'(4));
            chk($sformatf("v%0d_votes", v), 128'(votes), 128'(ev));
            chk($sformatf("v%0d_busy", v), 128'(busy), 128'(1));
            accept();
            chk($sformatf("v%0d_votes_held", v), 128'(votes), 128'(ev));
        end

        // DONE stall: ready low, stray start and finish must be ignored.
        ev = exp_votes(10'b00_0000_1000, 10'b00_1000_0000);
        run_cls(10'b00_0000_1000, 10'b00_1000_0000, 2, lat);
        chk("stall_latency", 128'(lat), 128'(23));
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            layer_finish = 1'b1;
            sample = 10'b11_1111_1111;
            tick();
            chk($sformatf("stall%0d_valid", k), 128'(result_valid), 128'(1));
            chk($sformatf("stall%0d_class", k), 128'(class_id), 128'(3));
            chk($sformatf("stall%0d_votes", k), 128'(votes), 128'(ev));
        end
        start = 1'b0;
        layer_finish = 1'b0;
        accept();
        chk("idle_class_held", 128'(class_id), 128'(3));
        chk("idle_iter_held", 128'(iterations_done), 128'(4));

        // Reset during pass 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        layer_finish = 1'b1;
        sample = 10'b00_0001_0000;
        tick();
        layer_finish = 1'b0;
        tick();
        chk("midrst_in_run", 128'(layer_reset), 128'(0));
        chk("midrst_pass1_done", 128'(iterations_done), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_layer_reset", 128'(layer_reset), 128'(1));
        chk("midrst_votes", 128'(votes), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_valid", 128'(result_valid), 128'(0));
        chk("midrst_iter", 128'(iterations_done), 128'(0));
        chk("midrst_class", 128'(class_id), 128'(0));
        ev = exp_votes(10'b00_0000_0100, 10'b00_0000_0100);
        run_cls(10'b00_0000_0100, 10'b00_0000_0100, 3, lat);
        chk("postrst_latency", 128'(lat), 128'(27));
        chk("postrst_votes", 128'(votes), 128'(ev));
        chk("postrst_class", 128'(class_id), 128'(2));
        accept();

        // Finish held high: one count per RUN entry.
        layer_finish = 1'b1;
        sample = 10'b00_0000_0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!result_valid && lat < 400) begin
            tick();
            lat++;
        end
        layer_finish = 1'b0;
        chk("held_latency", 128'(lat), 128'(19));
        chk("held_votes", 128'(votes), 128'(120'd4 << 12));
        chk("held_iter", 128'(iterations_done), 128'(4));
        accept();

        // Narrow counters: saturation, or early stop when enabled.
        layer_finish2 = 1'b1;
`ifdef VOTE_EARLY_STOP_EN
        sample2 = 10'b00_0010_0000;
`else
        sample2 = 10'b00_0000_0001;
`endif
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 1;
        while (!result_valid2 && lat < 400) begin
            tick();
            lat++;
        end
        layer_finish2 = 1'b0;
`ifdef VOTE_EARLY_STOP_EN
        ev2 = 20'd3 << 10;
        chk("sat_latency", 128'(lat), 128'(17));
        chk("sat_iter", 128'(iterations_done2), 128'(3));
        chk("sat_class", 128'(class_id2), 128'(5));
`else
        ev2 = 20'd3;
        chk("sat_latency", 128'(lat), 128'(23));
        chk("sat_iter", 128'(iterations_done2), 128'(6));
        chk("sat_class", 128'(class_id2), 128'(0));
`endif
        chk("sat_votes", 128'(votes2), 128'(ev2));
        chk("sat_valid", 128'(result_valid2), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
